// File: rtl/dma_multichannel.sv
// Multi-channel memory-to-memory DMA engine with round-robin channel selection.
// Every word is read, latched and written within one bus tenure of at most BURST words.
module dma_multichannel #(
  parameter int NCH   = 2,
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int CW    = 6,
  parameter int BURST = 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cfg_valid,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [AW-1:0]  cfg_src,
  input  logic [AW-1:0]  cfg_dst,
  input  logic [CW-1:0]  cfg_count,
  output logic           cfg_err,
  output logic           bus_req,
  input  logic           bus_grant,
  output logic [AW-1:0]  bus_addr,
  output logic           bus_rd,
  output logic           bus_wr,
  input  logic [DW-1:0]  bus_rdata,
  output logic [DW-1:0]  bus_wdata,
  output logic [NCH-1:0] ch_busy,
  output logic [NCH-1:0] ch_done
);
  localparam int unsigned NCHU = NCH;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_LATCH, S_WRITE, S_RELEASE} state_t;
  state_t state, state_nx;

  logic [AW-1:0]  src [NCH];
  logic [AW-1:0]  dst [NCH];
  logic [CW-1:0]  idx [NCH];
  logic [CW-1:0]  rem [NCH];
  logic [CHW-1:0] ptr, cur, pick, cand;
  logic           pick_valid;
  logic [CW-1:0]  burst_cnt;
  logic [DW-1:0]  hold;
  logic           cfg_in_range, last_word;

  assign cfg_in_range = (32'(cfg_ch) < NCHU);
  assign last_word    = (rem[cur] == CW'(1));

  // Scan starts just after the last served channel so every busy channel gets a turn.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= NCHU; k++) begin
      cand = CHW'((32'(ptr) + k) % NCHU);
      if (!pick_valid && ch_busy[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (pick_valid) state_nx = S_REQ;
      S_REQ:     if (bus_grant) state_nx = S_READ;
      S_READ:    state_nx = S_LATCH;
      S_LATCH:   state_nx = S_WRITE;
      S_WRITE: begin
        if (last_word || burst_cnt == CW'(BURST - 1) || !bus_grant) state_nx = S_RELEASE;
        else                                                         state_nx = S_READ;
      end
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      S_REQ, S_LATCH: bus_req = 1'b1;
      S_READ: begin
        bus_req  = 1'b1;
        bus_rd   = 1'b1;
        bus_addr = src[cur] + AW'(idx[cur]);
      end
      S_WRITE: begin
        bus_req   = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = dst[cur] + AW'(idx[cur]);
        bus_wdata = hold;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ch_busy   <= '0;
      ch_done   <= '0;
      cfg_err   <= 1'b0;
      ptr       <= CHW'(NCH - 1);
      cur       <= '0;
      hold      <= '0;
      burst_cnt <= '0;
      for (int unsigned k = 0; k < NCHU; k++) begin
        src[k] <= '0;
        dst[k] <= '0;
        idx[k] <= '0;
        rem[k] <= '0;
      end
    end else begin
      ch_done <= '0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE:    if (pick_valid) cur <= pick;
        S_REQ:     burst_cnt <= '0;
        S_LATCH:   hold <= bus_rdata;
        S_WRITE: begin
          idx[cur]  <= idx[cur] + CW'(1);
          rem[cur]  <= rem[cur] - CW'(1);
          burst_cnt <= burst_cnt + CW'(1);
          if (last_word) begin
            ch_busy[cur] <= 1'b0;
            ch_done[cur] <= 1'b1;
          end
        end
        S_RELEASE: ptr <= cur;
        default: ;
      endcase
      // A channel finishing this cycle is still busy here, so a load to it is rejected.
      if (cfg_valid) begin
        if (!cfg_in_range || ch_busy[cfg_ch]) begin
          cfg_err <= 1'b1;
        end else if (cfg_count == '0) begin
          ch_done[cfg_ch] <= 1'b1;
        end else begin
          src[cfg_ch]     <= cfg_src;
          dst[cfg_ch]     <= cfg_dst;
          idx[cfg_ch]     <= '0;
          rem[cfg_ch]     <= cfg_count;
          ch_busy[cfg_ch] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dma_multichannel.sv
// Scoreboard bench for dma_multichannel: per-channel word queues filled at load time,
// drained by a negedge monitor that follows bus tenures and round-robin order.
module tb_dma_multichannel;
  localparam int NCH = 2, AW = 8, DW = 32, CW = 6, BURST = 4, CHW = 1;

  logic           clock = 1'b0;
  logic           reset, cfg_valid, cfg_err, bus_req, bus_grant, bus_rd, bus_wr;
  logic [CHW-1:0] cfg_ch;
  logic [AW-1:0]  cfg_src, cfg_dst, bus_addr;
  logic [CW-1:0]  cfg_count;
  logic [DW-1:0]  bus_rdata, bus_wdata;
  logic [NCH-1:0] ch_busy, ch_done;

  always #5 clock = ~clock;

  dma_multichannel #(.NCH(NCH), .AW(AW), .DW(DW), .CW(CW), .BURST(BURST)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count), .cfg_err(cfg_err),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_rd(bus_rd),
    .bus_wr(bus_wr), .bus_rdata(bus_rdata), .bus_wdata(bus_wdata),
    .ch_busy(ch_busy), .ch_done(ch_done)
  );

  typedef struct packed { logic [AW-1:0] s; logic [AW-1:0] d; } word_t;
  word_t          q [NCH][$];
  logic [NCH-1:0] busy_m = '0, busy_prev = '0, pend_clr = '0, exp_done = '0;
  logic           exp_err = 1'b0;
  logic [DW-1:0]  held;
  int             ptr_m = NCH - 1, cur_m = 0, words = 0, ph = 0;
  int             n_chk = 0, n_pass = 0, gmode = 1;
  bit             mon_en = 1'b0, manual_grant = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  initial begin
    bus_grant = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      bus_rdata = $urandom;
      if (gmode == 0)      bus_grant = ($urandom_range(0, 3) != 0);
      else if (gmode == 1) bus_grant = 1'b1;
      else                 bus_grant = manual_grant;
    end
  end

  // ph: 0 no tenure, 1 requesting, 2 read, 3 latch, 4 write, 5 release, 6 idle after release
  always @(negedge clock) begin : mon
    int c;
    if (mon_en) begin
      busy_m   = busy_m & ~pend_clr;
      pend_clr = '0;
      chk("ch_busy", 64'(ch_busy), 64'(busy_m));
      chk("cfg_err", 64'(cfg_err), 64'(exp_err));
      exp_err = 1'b0;
      chk("ch_done", 64'(ch_done), 64'(exp_done));
      exp_done = '0;
      chk("rd_wr_exclusive", 64'(bus_rd && bus_wr), 64'(0));
      if (ph == 0 && bus_req) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (ptr_m + k) % NCH;
          if (ph == 0 && busy_prev[c]) begin
            cur_m = c;
            words = 0;
            ph    = 1;
          end
        end
      end
      chk("bus_req", 64'(bus_req), 64'(ph >= 1 && ph <= 4));
      chk("bus_rd", 64'(bus_rd), 64'(ph == 2));
      chk("bus_wr", 64'(bus_wr), 64'(ph == 4));
      if (ph != 2 && ph != 4) chk("bus_addr_idle", 64'(bus_addr), 64'(0));
      if (ph != 4) chk("bus_wdata_idle", 64'(bus_wdata), 64'(0));
      case (ph)
        1: if (bus_grant) ph = 2;
        2: begin
          if (q[cur_m].size() == 0) chk("unexpected_read", 64'(bus_rd), 64'(0));
          else chk("rd_addr", 64'(bus_addr), 64'(q[cur_m][0].s));
          ph = 3;
        end
        3: begin
          held = bus_rdata;
          ph   = 4;
        end
        4: begin
          if (q[cur_m].size() != 0) begin
            chk("wr_addr", 64'(bus_addr), 64'(q[cur_m][0].d));
            chk("wr_data", 64'(bus_wdata), 64'(held));
            void'(q[cur_m].pop_front());
          end
          words++;
          if (q[cur_m].size() == 0) begin
            exp_done[cur_m] = 1'b1;
            pend_clr[cur_m] = 1'b1;
            ph = 5;
          end else if (words == BURST || !bus_grant) begin
            ph = 5;
          end else begin
            ph = 2;
          end
          if (ph == 5) ptr_m = cur_m;
        end
        5: ph = 6;
        6: ph = 0;
        default: ;
      endcase
      busy_prev = busy_m;
    end
  end

  // Called at posedge+1; the descriptor is sampled at the following edge.
  task automatic load(input int ch, input int src, input int dst, input int cnt);
    word_t w;
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_src   = AW'(src);
    cfg_dst   = AW'(dst);
    cfg_count = CW'(cnt);
    @(posedge clock);
    if (ch >= NCH || busy_m[ch]) exp_err = 1'b1;
    else if (cnt == 0) exp_done[ch] = 1'b1;
    else begin
      for (int i = 0; i < cnt; i++) begin
        w.s = AW'(src + i);
        w.d = AW'(dst + i);
        q[ch].push_back(w);
      end
      busy_m[ch] = 1'b1;
    end
    #1 cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock);
      #1;
      if (busy_m == '0 && ph == 0 && ch_busy == '0) break;
    end
    chk("drain_busy", 64'(ch_busy), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nrd;
    reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_src = '0; cfg_dst = '0; cfg_count = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_bus_req", 64'(bus_req), 64'(0));
    chk("rst_bus_rd", 64'(bus_rd), 64'(0));
    chk("rst_bus_wr", 64'(bus_wr), 64'(0));
    chk("rst_bus_addr", 64'(bus_addr), 64'(0));
    chk("rst_bus_wdata", 64'(bus_wdata), 64'(0));
    chk("rst_ch_busy", 64'(ch_busy), 64'(0));
    chk("rst_ch_done", 64'(ch_done), 64'(0));
    chk("rst_cfg_err", 64'(cfg_err), 64'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    gmode = 1;
    load(0, 10, 200, 3);  drain();
    load(0, 20, 100, 6);  load(1, 40, 140, 2);  drain();
    load(1, 254, 60, 3);  drain();
    load(1, 80, 90, 5);   load(1, 1, 2, 3);  load(0, 5, 5, 0);  drain();

    gmode = 2; manual_grant = 1'b1;
    load(0, 30, 130, 5);
    nrd = 0;
    for (int i = 0; i < 100 && nrd < 2; i++) begin
      @(negedge clock);
      if (bus_rd) nrd++;
    end
    chk("second_read_seen", 64'(nrd), 64'(2));
    manual_grant = 1'b0;
    repeat (8) @(posedge clock);
    #1 manual_grant = 1'b1;
    drain();

    gmode = 0;
    repeat (80) begin
      load($urandom_range(0, NCH - 1), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 9));
      idle($urandom_range(0, 10));
    end
    drain();

    gmode = 1;
    load(0, 77, 177, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus_wr) break;
    end
    chk("write_seen", 64'(bus_wr), 64'(1));
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    chk("abort_bus_req", 64'(bus_req), 64'(0));
    chk("abort_bus_rd", 64'(bus_rd), 64'(0));
    chk("abort_bus_wr", 64'(bus_wr), 64'(0));
    chk("abort_bus_addr", 64'(bus_addr), 64'(0));
    chk("abort_bus_wdata", 64'(bus_wdata), 64'(0));
    chk("abort_ch_busy", 64'(ch_busy), 64'(0));
    chk("abort_ch_done", 64'(ch_done), 64'(0));
    @(negedge clock);
    chk("abort_ch_done_late", 64'(ch_done), 64'(0));
    for (int k = 0; k < NCH; k++) q[k].delete();
    busy_m = '0; busy_prev = '0; pend_clr = '0; exp_done = '0; exp_err = 1'b0;
    ph = 0; ptr_m = NCH - 1;
    @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    load(1, 250, 3, 2);  load(0, 8, 9, 5);  drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dma_multichannel.md
DMA_MULTICHANNEL -- requirements
Module: dma_multichannel

Interface
REQ-001 Parameter NCH, default 2: number of independent DMA channels, range 1..8.
REQ-002 Parameter AW, default 8: bus address width.
REQ-003 Parameter DW, default 32: bus data width.
REQ-004 Parameter CW, default 6: transfer-count width.
REQ-005 Parameter BURST, default 4: maximum words moved per bus tenure before re-arbitration, range 1..2^CW-1.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- cfg_valid  in  1  descriptor load strobe.
- cfg_ch  in  max(1,clog2(NCH))  target channel.
- cfg_src  in  AW  source start address.
- cfg_dst  in  AW  destination start address.
- cfg_count  in  CW  word count.
- cfg_err  out  1  one-cycle pulse: load rejected.
- bus_req  out  1  bus request to processor.
- bus_grant  in  1  processor grant.
- bus_addr  out  AW  bus address.
- bus_rd  out  1  read strobe.
- bus_wr  out  1  write strobe.
- bus_rdata  in  DW  read data, valid the cycle after bus_rd.
- bus_wdata  out  DW  write data.
- ch_busy  out  NCH  channel holds an unfinished descriptor.
- ch_done  out  NCH  one-cycle completion pulse per channel.

Function
REQ-007 Load: cfg_valid with ch_busy[cfg_ch]=0 stores src/dst/count and sets ch_busy[cfg_ch] next cycle; cfg_valid to a busy channel or cfg_ch>=NCH is ignored and pulses cfg_err next cycle.
REQ-008 cfg_count=0: descriptor not stored, ch_busy stays 0, ch_done[cfg_ch] pulses next cycle, no bus cycles.
REQ-009 FSM states IDLE, REQ, READ, LATCH, WRITE, RELEASE.
REQ-010 IDLE: if any ch_busy, select channel by round-robin starting after last served channel (reset pointer: channel NCH-1, so channel 0 first) -> REQ.
REQ-011 REQ: bus_req=1; stays until bus_grant=1 sampled -> READ.
REQ-012 READ (1 cycle): bus_rd=1, bus_addr=src+idx -> LATCH.
REQ-013 LATCH (1 cycle): bus_rdata registered into hold buffer -> WRITE.
REQ-014 WRITE (1 cycle): bus_wr=1, bus_addr=dst+idx, bus_wdata=hold; idx increments, remaining count decrements.
REQ-015 After WRITE: remaining=0 -> ch_done pulse, ch_busy clear, RELEASE; else words-this-tenure=BURST or bus_grant=0 -> RELEASE; else -> READ.
REQ-016 RELEASE (1 cycle): bus_req=0, strobes 0, pointer updated -> IDLE; unfinished channel keeps progress (idx, remaining).
REQ-017 bus_req high in REQ, READ, LATCH, WRITE; grant loss mid-word never aborts a started word.
REQ-018 Addresses wrap modulo 2^AW; one word costs 3 cycles under grant.
REQ-019 bus_rd and bus_wr never both high; bus_addr and bus_wdata 0 when no strobe.
REQ-020 A load to an idle channel in the same cycle another channel completes is accepted.

Reset
REQ-021 Reset clears all descriptors, ch_busy=0, ch_done=0, cfg_err=0, bus_req=0, bus_rd=0, bus_wr=0, bus_addr=0, bus_wdata=0, pointer to NCH-1, FSM to IDLE.
REQ-022 Reset mid-transfer aborts with no further strobe in the following cycle and no ch_done pulse.

Verification
REQ-023 Ch0 src=10 dst=200 count=3, grant held: reads 10,11,12, writes 200,201,202 with captured data, ch_done[0] 9 cycles after first READ.
REQ-024 Ch0 count=6 and ch1 count=2 loaded together, BURST=4: ch0 moves 4 words, release, ch1 moves 2, then ch0 final 2.
REQ-025 src=254 count=3: reads 254,255,0 (wrap).
REQ-026 Load to busy ch1 -> cfg_err pulse, descriptor unchanged; count=0 -> ch_done pulse, no bus_req.
REQ-027 Grant dropped during LATCH of word 2: word 2 write completes, RELEASE, resumes word 3 after re-grant.
REQ-028 Reset asserted during WRITE -> all outputs 0 next cycle, ch_busy=0, no ch_done.
